// File: rtl/element_rotate_sel.sv
// element_rotate_sel
//   Rotating (data-weighted averaging) selector for a 6-element unit array.
//   Each consumed sample asks for `beta` elements at the one level and `gama`
//   elements at the zero level. The elements are taken as one contiguous
//   cyclic run that starts at the rotation pointer. The ones come first and
//   the zeros follow them. In rotating mode the pointer then advances past
//   the whole run. In static mode the run always starts at element 0.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   clk_en     sample strobe; one sample is consumed per cycle with clk_en=1
//   gama[1:0]  number of elements driven to the zero level (0..3)
//   beta[1:0]  number of elements driven to the one level (0..3)
//   mode       0 = rotating selection, 1 = static selection from element 0
//   sel_one    registered mask of elements set to one
//   sel_zero   registered mask of elements set to zero
//   out_valid  registered pulse, high the cycle after a consumed sample
//   ptr        current rotation pointer (0..5)
module element_rotate_sel (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clk_en,
  input  logic [1:0] gama,
  input  logic [1:0] beta,
  input  logic       mode,
  output logic [5:0] sel_one,
  output logic [5:0] sel_zero,
  output logic       out_valid,
  output logic [2:0] ptr
);

  // Reduce a sum of at most 11 to the range 0..5. One subtraction is enough.
  function automatic logic [2:0] wrap6(input logic [3:0] s);
    logic [3:0] r;
    r = (s >= 4'd6) ? (s - 4'd6) : s;
    return r[2:0];
  endfunction

  // Rotate a 6-bit mask left by p positions, where p is 0..5.
  function automatic logic [5:0] rotl6(input logic [5:0] m, input logic [2:0] p);
    logic [11:0] d;
    d = {m, m} << p;
    return d[11:6];
  endfunction

  logic [5:0] sel_one_p1;
  logic [5:0] sel_zero_p1;
  logic       vld_p1;
  logic [2:0] ptr_p1;

  logic [2:0] eff_ptr_p0;
  logic [2:0] tot_p0;
  logic [5:0] run_one_p0;
  logic [5:0] run_all_p0;
  logic [5:0] one_p0;
  logic [5:0] zero_p0;
  logic [3:0] sum_p0;
  logic [2:0] ptr_next_p0;

  // ---- stage p0: masks from the pre-update pointer, next pointer ----
  always_comb begin
    eff_ptr_p0  = mode ? 3'd0 : ptr_p1;
    tot_p0      = {1'b0, beta} + {1'b0, gama};
    // The ones and zeros are unrotated runs anchored at bit 0.
    // The ones occupy the low beta bits. The zeros occupy the next gama bits.
    run_one_p0  = (6'd1 << beta) - 6'd1;
    run_all_p0  = 6'((7'd1 << tot_p0) - 7'd1);
    one_p0      = rotl6(run_one_p0, eff_ptr_p0);
    zero_p0     = rotl6(run_all_p0 & ~run_one_p0, eff_ptr_p0);
    sum_p0      = {1'b0, ptr_p1} + {1'b0, tot_p0};
    ptr_next_p0 = mode ? 3'd0 : wrap6(sum_p0);
  end

  // ---- stage p1: registered outputs and pointer state ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_one_p1  <= '0;
      sel_zero_p1 <= '0;
      vld_p1      <= 1'b0;
      ptr_p1      <= '0;
    end else begin
      vld_p1 <= clk_en;
      if (clk_en) begin
        sel_one_p1  <= one_p0;
        sel_zero_p1 <= zero_p0;
        ptr_p1      <= ptr_next_p0;
      end
    end
  end

  assign sel_one   = sel_one_p1;
  assign sel_zero  = sel_zero_p1;
  assign out_valid = vld_p1;
  assign ptr       = ptr_p1;

endmodule

// File: tb/tb_element_rotate_sel.sv
module tb_element_rotate_sel;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clk_en = 1'b0;
  logic [1:0] gama = '0;
  logic [1:0] beta = '0;
  logic       mode = 1'b0;
  logic [5:0] sel_one, sel_zero;
  logic       out_valid;
  logic [2:0] ptr;

  int tests = 0;
  int fails = 0;

  element_rotate_sel dut (
    .clk(clk), .rstn(rstn), .clk_en(clk_en), .gama(gama), .beta(beta),
    .mode(mode), .sel_one(sel_one), .sel_zero(sel_zero),
    .out_valid(out_valid), .ptr(ptr)
  );

  always #5 clk = ~clk;

  // Behavioural model: the element selection is computed directly from the
  // index rules (element (p+k) mod 6), using integer arithmetic.
  int   m_ptr = 0;
  logic [5:0] m_one = '0, m_zero = '0;
  logic m_vld = 1'b0;
  int   m_b = 0, m_g = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ptr = 0; m_one = '0; m_zero = '0; m_vld = 1'b0; m_b = 0; m_g = 0;
    end else begin
      m_vld = clk_en;
      if (clk_en) begin
        int p;
        p = mode ? 0 : m_ptr;
        m_b = int'(beta);
        m_g = int'(gama);
        m_one = '0;
        m_zero = '0;
        for (int k = 0; k < m_b; k++) m_one[(p + k) % 6] = 1'b1;
        for (int k = m_b; k < m_b + m_g; k++) m_zero[(p + k) % 6] = 1'b1;
        m_ptr = mode ? 0 : (m_ptr + m_b + m_g) % 6;
      end
    end
  end

  // Per-element usage (one or zero) during the random run.
  bit usage_en = 1'b0;
  int use_cnt [6];

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [15:0] act, exp;
    act = {sel_one, sel_zero, out_valid, ptr};
    exp = {m_one, m_zero, m_vld, 3'(m_ptr)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_model t=%0t: got one=%b zero=%b vld=%b ptr=%0d, want one=%b zero=%b vld=%b ptr=%0d",
               $time, sel_one, sel_zero, out_valid, ptr, m_one, m_zero, m_vld, m_ptr);
    end
    if (out_valid === 1'b1) begin
      tests++;
      if ((sel_one & sel_zero) != 6'd0 || $countones(sel_one) != m_b ||
          $countones(sel_zero) != m_g) begin
        fails++;
        $display("FAIL invariant t=%0t: one=%b zero=%b, want disjoint with %0d ones and %0d zeros",
                 $time, sel_one, sel_zero, m_b, m_g);
      end
      if (usage_en)
        for (int e = 0; e < 6; e++)
          if (sel_one[e] || sel_zero[e]) use_cnt[e]++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // The DUT and the model are both compared against hand-computed literals.
  task automatic chk_all(input string name, input logic [5:0] one,
                         input logic [5:0] zero, input logic vld,
                         input logic [2:0] p);
    chk({name, ".one"},  int'(sel_one),  int'(one));
    chk({name, ".zero"}, int'(sel_zero), int'(zero));
    chk({name, ".vld"},  int'(out_valid), int'(vld));
    chk({name, ".ptr"},  int'(ptr), int'(p));
    chk({name, ".model"}, int'({m_one, m_zero, m_vld, 3'(m_ptr)}),
        int'({one, zero, vld, p}));
  endtask

  // Drive one cycle of stimulus, then return 1 time unit after the edge.
  task automatic cyc(input logic en, input int b, input int g, input logic md);
    clk_en = en; beta = 2'(b); gama = 2'(g); mode = md;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 6'b000000, 6'b000000, 1'b0, 3'd0);
    @(negedge clk); #1 rstn = 1'b1;

    // Basic sample, then a sample that wraps around
    cyc(1, 3, 2, 0); chk_all("b3g2",  6'b000111, 6'b011000, 1'b1, 3'd5);
    cyc(1, 2, 1, 0); chk_all("wrap",  6'b100001, 6'b000010, 1'b1, 3'd2);

    // Static mode
    cyc(1, 1, 3, 1); chk_all("static1", 6'b000001, 6'b001110, 1'b1, 3'd0);
    cyc(1, 1, 3, 1); chk_all("static2", 6'b000001, 6'b001110, 1'b1, 3'd0);

    // Hold while clk_en is low
    for (int i = 0; i < 4; i++) begin
      cyc(0, i, 3 - i, i[0]);
      chk_all("hold", 6'b000001, 6'b001110, 1'b0, 3'd0);
    end

    // Empty sample, then a sample that fills the whole array
    cyc(1, 0, 0, 0); chk_all("empty", 6'b000000, 6'b000000, 1'b1, 3'd0);
    cyc(1, 2, 2, 0); chk_all("to4",   6'b000011, 6'b001100, 1'b1, 3'd4);
    cyc(1, 3, 3, 0); chk_all("full",  6'b110001, 6'b001110, 1'b1, 3'd4);

    // Asynchronous reset between clock edges while ptr = 4
    clk_en = 1'b1; beta = 2'd1; gama = 2'd1;
    #2 rstn = 1'b0;
    #1 chk_all("async_rst", 6'b000000, 6'b000000, 1'b0, 3'd0);
    @(negedge clk); #1 rstn = 1'b1;
    cyc(1, 3, 0, 0); chk_all("post_rst", 6'b000111, 6'b000000, 1'b1, 3'd3);

    // Random mode-0 run, with clk_en occasionally low
    cyc(0, 0, 0, 0);
    usage_en = 1'b1;
    for (int i = 0; i < 10000; i++)
      cyc(($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'b0);
    cyc(0, 0, 0, 0);
    usage_en = 1'b0;
    begin
      int mn, mx;
      mn = use_cnt[0]; mx = use_cnt[0];
      for (int e = 1; e < 6; e++) begin
        if (use_cnt[e] < mn) mn = use_cnt[e];
        if (use_cnt[e] > mx) mx = use_cnt[e];
      end
      tests++;
      if (mx - mn > 3 || mx == 0) begin
        fails++;
        $display("FAIL usage_spread: got max=%0d min=%0d, want spread <= 3", mx, mn);
      end
    end

    // Short random run with mixed modes
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
